// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add multiplier, one iteration per clock.
// Start/done handshake with optional two's-complement operands.
module seq_shift_add_mult #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1,
  localparam int NW       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [2*WIDTH-1:0] product,
  output logic [NW-1:0]    iter_left
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  logic [2*WIDTH-1:0] a;
  logic [2*WIDTH-1:0] b;
  logic [WIDTH-1:0]   q;
  logic [NW-1:0]      n;
  logic               neg;

  logic               sgn;
  logic [WIDTH-1:0]   x_mag;
  logic [WIDTH-1:0]   y_mag;
  logic               neg_in;

  // operand magnitudes and result sign for the load step
  always_comb begin
    sgn    = is_signed & SIGNED_EN;
    x_mag  = multiplicand;
    y_mag  = multiplier;
    if (sgn && multiplicand[WIDTH-1])
      x_mag = -multiplicand;
    if (sgn && multiplier[WIDTH-1])
      y_mag = -multiplier;
    neg_in = sgn & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
  end

  // merged FSM and datapath; a new op may load from IDLE or DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      a       <= '0;
      b       <= '0;
      q       <= '0;
      n       <= '0;
      neg     <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a     <= '0;
            b     <= {{WIDTH{1'b0}}, x_mag};
            q     <= y_mag;
            n     <= NW'(WIDTH);
            neg   <= neg_in;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          if (q[0])
            a <= a + b;
          b <= b << 1;
          q <= q >> 1;
          n <= n - NW'(1);
          if (n == NW'(1))
            state <= SIGN;
        end
        SIGN: begin
          product <= neg ? -a : a;
          done    <= 1'b1;
          state   <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign iter_left = n;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Scoreboard bench for seq_shift_add_mult.
// Directed vectors, WIDTH=32, SIGNED_EN=1.
module tb_seq_shift_add_mult;

  localparam int W = 32;

  typedef struct {
    logic [63:0] prod;
    int          at;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          is_signed = 1'b0;
  logic [W-1:0]  multiplicand = '0;
  logic [W-1:0]  multiplier = '0;
  logic          busy;
  logic          done;
  logic [2*W-1:0] product;
  logic [5:0]    iter_left;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_done = 0;
  int   k;

  seq_shift_add_mult #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .is_signed(is_signed),
    .multiplicand(multiplicand),
    .multiplier(multiplier),
    .busy(busy),
    .done(done),
    .product(product),
    .iter_left(iter_left)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // monitor: pop one expectation per done pulse
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: cycle %0d queue empty", cyc);
      end else begin
        e = sb.pop_front();
        check("product", product, e.prod);
        check("done_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  task automatic go(input logic [W-1:0] x, input logic [W-1:0] y,
                    input logic s, input logic [63:0] exp,
                    input bit track);
    @(negedge clk);
    start = 1'b1;
    multiplicand = x;
    multiplier = y;
    is_signed = s;
    @(posedge clk);
    #1;
    k = cyc;
    if (track) sb.push_back('{exp, cyc + W + 1});
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_idle;
    int t;
    t = 0;
    @(negedge clk);
    while ((busy !== 1'b0 || sb.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: busy=%b queue=%0d", busy, sb.size());
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", product, 64'd0);
    check("rst_iter", 64'(iter_left), 64'd0);
    reset = 1'b0;

    // T1
    go(32'd3, 32'd5, 1'b0, 64'h000000000000000F, 1'b1);
    @(negedge clk);
    check("t1_iter_first", 64'(iter_left), 64'd32);
    check("t1_busy_run", 64'(busy), 64'd1);
    wait_cyc(k + W + 1);
    check("t1_busy_done", 64'(busy), 64'd1);
    check("t1_done_high", 64'(done), 64'd1);
    @(negedge clk);
    check("t1_busy_fall", 64'(busy), 64'd0);
    check("t1_done_fall", 64'(done), 64'd0);
    check("t1_hold", product, 64'h000000000000000F);
    wait_idle();

    // T2
    go(32'hFFFFFFF9, 32'h00000006, 1'b1, 64'hFFFFFFFFFFFFFFD6, 1'b1);
    wait_idle();
    go(32'hFFFFFFF9, 32'h00000006, 1'b0, 64'h00000005FFFFFFD6, 1'b1);
    wait_idle();

    // T3
    go(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 1'b1);
    wait_idle();
    go(32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 1'b1);
    wait_idle();

    // T4: starts during RUN are ignored
    go(32'd1234, 32'd5678, 1'b0, 64'd7006652, 1'b1);
    wait_cyc(k + 5);
    start = 1'b1; multiplicand = 32'd99; multiplier = 32'd99;
    @(negedge clk);
    start = 1'b0;
    check("t4_prod_stable", product, 64'h4000000000000000);
    wait_cyc(k + 20);
    start = 1'b1; multiplicand = 32'd7; multiplier = 32'd11;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("t4_done_count", 64'(n_done), 64'd6);

    // T5: reset mid-operation
    go(32'd77, 32'd88, 1'b0, 64'd0, 1'b0);
    wait_cyc(k + 10);
    check("t5_iter_mid", 64'(iter_left), 64'd22);
    reset = 1'b1;
    @(negedge clk);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_done", 64'(done), 64'd0);
    check("t5_product", product, 64'd0);
    check("t5_iter", 64'(iter_left), 64'd0);
    reset = 1'b0;
    go(32'd9, 32'd9, 1'b0, 64'd81, 1'b1);
    wait_idle();

    // T6: start held high, three ops back-to-back
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0;
    multiplicand = 32'd2; multiplier = 32'd3;
    @(posedge clk); #1;
    sb.push_back('{64'd6, cyc + W + 1});
    is_signed = 1'b1;
    multiplicand = 32'hFFFFFFFF; multiplier = 32'hFFFFFFFF;
    repeat (W + 2) @(posedge clk);
    #1;
    sb.push_back('{64'd1, cyc + W + 1});
    multiplicand = 32'h7FFFFFFF; multiplier = 32'h80000000;
    repeat (W + 2) @(posedge clk);
    #1;
    sb.push_back('{64'hC000000080000000, cyc + W + 1});
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    check("total_done", 64'(n_done), 64'd10);
    check("queue_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
